// File: rtl/rv32m_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : rv32m_pkg
//  Description : Shared definitions for the RV32M multiply path. It holds the
//                funct3[1:0] op encodings, the stage-1 payload struct and a
//                helper that forms a two's-complement magnitude.
//  Revision    : 1.0 - initial release
// ============================================================================
package rv32m_pkg;

  localparam logic [1:0] MUL_OP_MUL    = 2'b00;
  localparam logic [1:0] MUL_OP_MULH   = 2'b01;
  localparam logic [1:0] MUL_OP_MULHSU = 2'b10;
  localparam logic [1:0] MUL_OP_MULHU  = 2'b11;

  // Width of the tag field in the shared payload struct. Units that carry a
  // narrower or equal tag size-cast into and out of this field.
  localparam int RV32M_TAG_W = 5;

  typedef struct packed {
    logic [31:0]            mag_a;
    logic [31:0]            mag_b;
    logic                   neg;
    logic                   sel_hi;
    logic [RV32M_TAG_W-1:0] tag;
  } s1_payload_t;

  // Conditional 32-bit negate. 0x80000000 maps onto itself, and that is the
  // correct unsigned magnitude of -2^31.
  function automatic logic [31:0] rv32m_mag(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rv32m_sign_fix.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : rv32m_sign_fix
//  Description : Applies a conditional two's-complement negate to a 64-bit
//                unsigned product and selects its high or low word. The
//                divide unit shares this block.
//  Ports       : prod_i   - unsigned 64-bit magnitude
//                neg_i    - negate the magnitude
//                sel_hi_i - 1 selects bits [63:32], 0 selects bits [31:0]
//                word_o   - selected 32-bit word
//  Revision    : 1.0 - initial release
// ============================================================================
module rv32m_sign_fix (
  input  logic [63:0] prod_i,
  input  logic        neg_i,
  input  logic        sel_hi_i,
  output logic [31:0] word_o
);

  logic [63:0] fixed_w;

  assign fixed_w = neg_i ? (~prod_i + 64'd1) : prod_i;
  assign word_o  = sel_hi_i ? fixed_w[63:32] : fixed_w[31:0];

endmodule
`default_nettype wire

// File: rtl/rv32m_umul32.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : rv32m_umul32
//  Description : Unsigned 32x32 -> 64 multiply core (combinational).
//  Ports       : a_i, b_i  - unsigned operands
//                p_o       - full 64-bit product
//  Revision    : 1.0 - initial release
// ============================================================================
module rv32m_umul32 (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [63:0] p_o
);

  assign p_o = {32'd0, a_i} * {32'd0, b_i};

endmodule
`default_nettype wire

// File: rtl/rv32m_mul_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : rv32m_mul_unit
//  Description : Two-stage elastic RV32M MUL/MULH/MULHSU/MULHU unit.
//                S1 captures the operand magnitudes and the result sign.
//                S2 captures the unsigned 64-bit product. The output word is
//                the sign-fixed selection of the S2 register.
//  Ports       : clk, clrn (async active-low reset), flush
//                in_valid/in_ready, op, rs1, rs2, in_tag  - request side
//                out_valid/out_ready, result, out_tag     - response side
//                busy                                     - either stage full
//  Option      : `define RV32M_MUL_PERF_CNT_EN adds the 32-bit mul_count
//                output, which counts retired results.
//  Revision    : 1.0 - initial release
// ============================================================================
module rv32m_mul_unit
  import rv32m_pkg::*;
#(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [31:0]      rs1,
  input  logic [31:0]      rs2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
`ifdef RV32M_MUL_PERF_CNT_EN
  ,
  output logic [31:0]      mul_count
`endif
);

  logic        s1_valid_q;
  s1_payload_t s1_q;
  s1_payload_t s1_d;

  logic             s2_valid_q;
  logic [63:0]      s2_prod_q;
  logic             s2_neg_q;
  logic             s2_sel_hi_q;
  logic [TAG_W-1:0] s2_tag_q;

  logic        a_neg_w;
  logic        b_neg_w;
  logic        s1_adv_w;
  logic        s2_adv_w;
  logic [63:0] prod_w;

  // MUL uses unsigned operands because the low word does not depend on sign.
  always_comb begin
    a_neg_w      = ((op == MUL_OP_MULH) || (op == MUL_OP_MULHSU)) & rs1[31];
    b_neg_w      = (op == MUL_OP_MULH) & rs2[31];
    s1_d         = '0;
    s1_d.mag_a   = rv32m_mag(rs1, a_neg_w);
    s1_d.mag_b   = rv32m_mag(rs2, b_neg_w);
    s1_d.neg     = a_neg_w ^ b_neg_w;
    s1_d.sel_hi  = (op != MUL_OP_MUL);
    s1_d.tag     = RV32M_TAG_W'(in_tag);
  end

  assign s2_adv_w  = !s2_valid_q | out_ready;
  assign s1_adv_w  = !s1_valid_q | s2_adv_w;
  assign in_ready  = s1_adv_w;
  assign out_valid = s2_valid_q;
  assign busy      = s1_valid_q | s2_valid_q;

  rv32m_umul32 u_umul (
    .a_i (s1_q.mag_a),
    .b_i (s1_q.mag_b),
    .p_o (prod_w)
  );

  // A flush clears only the valid bits. The payload registers keep their
  // values, so result stays stable while out_valid is low.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      s1_valid_q  <= 1'b0;
      s1_q        <= '0;
      s2_valid_q  <= 1'b0;
      s2_prod_q   <= 64'd0;
      s2_neg_q    <= 1'b0;
      s2_sel_hi_q <= 1'b0;
      s2_tag_q    <= '0;
    end else if (flush) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      if (s1_adv_w) begin
        s1_valid_q <= in_valid;
        if (in_valid) begin
          s1_q <= s1_d;
        end
      end
      if (s2_adv_w) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_prod_q   <= prod_w;
          s2_neg_q    <= s1_q.neg;
          s2_sel_hi_q <= s1_q.sel_hi;
          s2_tag_q    <= TAG_W'(s1_q.tag);
        end
      end
    end
  end

  rv32m_sign_fix u_sign_fix (
    .prod_i   (s2_prod_q),
    .neg_i    (s2_neg_q),
    .sel_hi_i (s2_sel_hi_q),
    .word_o   (result)
  );

  assign out_tag = s2_tag_q;

`ifdef RV32M_MUL_PERF_CNT_EN
  logic [31:0] mul_count_q;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      mul_count_q <= 32'd0;
    end else if (s2_valid_q & out_ready & !flush) begin
      mul_count_q <= mul_count_q + 32'd1;
    end
  end

  assign mul_count = mul_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rv32m_mul_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_rv32m_mul_unit
//  Description : Self-checking bench for rv32m_mul_unit. Expected results go
//                into a queue when an op is accepted. They are popped and
//                compared when the unit retires a result.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rv32m_mul_unit;

  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             clrn = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [1:0]       op = 2'b00;
  logic [31:0]      rs1 = 32'd0;
  logic [31:0]      rs2 = 32'd0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      result;
  logic [TAG_W-1:0] out_tag;
  logic             busy;
`ifdef RV32M_MUL_PERF_CNT_EN
  logic [31:0]      mul_count;
`endif

  rv32m_mul_unit #(.TAG_W(TAG_W)) dut (
    .clk       (clk),
    .clrn      (clrn),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .rs1       (rs1),
    .rs2       (rs2),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .out_tag   (out_tag),
    .busy      (busy)
`ifdef RV32M_MUL_PERF_CNT_EN
    ,
    .mul_count (mul_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]      res;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Handshake events sampled just before the most recent rising edge.
  bit               acc;
  bit               ret;
  logic [31:0]      obs_res;
  logic [TAG_W-1:0] obs_tag;

  // Reference model. It sign-extends the operands to 64 bits and multiplies
  // modulo 2^64, which gives the exact product for every RV32M variant.
  function automatic logic [31:0] model(input logic [1:0] m_op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] xa;
    logic [63:0] xb;
    logic [63:0] p;
    xa = (m_op == 2'b01 || m_op == 2'b10) ? {{32{a[31]}}, a} : {32'd0, a};
    xb = (m_op == 2'b01) ? {{32{b[31]}}, b} : {32'd0, b};
    p  = xa * xb;
    return (m_op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  // Samples the handshakes that happen at the coming edge, then advances one cycle.
  task automatic cycle();
    #1;
    acc     = in_valid && in_ready && !flush;
    ret     = out_valid && out_ready && !flush;
    obs_res = result;
    obs_tag = out_tag;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (result !== 32'd0) begin n_fail++; $display("FAIL reset_result: got %h want 0", result); end
    n_checks++; if (out_tag !== '0) begin n_fail++; $display("FAIL reset_out_tag: got %h want 0", out_tag); end
    @(negedge clk);
    clrn = 1'b1;
    @(posedge clk);
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
`ifdef RV32M_MUL_PERF_CNT_EN
    n_checks++; if (mul_count !== 32'd0) begin n_fail++; $display("FAIL reset_mul_count: got %0d want 0", mul_count); end
`endif
  endtask

  task automatic test_back_to_back();
    exp_t e;
    out_ready = 1'b1;
    in_valid = 1'b1; op = 2'b11; rs1 = 32'hFFFF_FFFF; rs2 = 32'hFFFF_FFFF; in_tag = 5'd1;
    cycle();
    n_checks++; if (!acc) begin n_fail++; $display("FAIL b2b_accept1: accept got 0 want 1"); end
    exp_q.push_back('{32'hFFFF_FFFE, 5'd1});
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_latency1: out_valid got %b want 0", out_valid); end
    op = 2'b00; in_tag = 5'd2;
    cycle();
    n_checks++; if (!acc) begin n_fail++; $display("FAIL b2b_accept2: accept got 0 want 1"); end
    exp_q.push_back('{32'h0000_0001, 5'd2});
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_latency2: out_valid got %b want 1", out_valid); end
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cycle();
      n_checks++;
      if (!ret || exp_q.size() == 0) begin
        n_fail++; $display("FAIL b2b_retire%0d: retire got %b want 1", i, ret);
      end else begin
        e = exp_q.pop_front();
        if (obs_res !== e.res || obs_tag !== e.tag) begin
          n_fail++; $display("FAIL b2b_result%0d: got %h/tag %0d want %h/tag %0d", i, obs_res, obs_tag, e.res, e.tag);
        end
      end
    end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: busy got %b want 0", busy); end
    exp_q.delete();
  endtask

  task automatic test_signed();
    exp_t e;
    logic [1:0]  v_op  [5];
    logic [31:0] v_a   [5];
    logic [31:0] v_b   [5];
    logic [31:0] v_exp [5];
    int issued;
    v_op[0] = 2'b01; v_a[0] = 32'h8000_0000; v_b[0] = 32'h8000_0000; v_exp[0] = 32'h4000_0000;
    v_op[1] = 2'b01; v_a[1] = 32'hFFFF_FFFF; v_b[1] = 32'hFFFF_FFFF; v_exp[1] = 32'h0000_0000;
    v_op[2] = 2'b01; v_a[2] = 32'hFFFF_FFFF; v_b[2] = 32'h0000_0002; v_exp[2] = 32'hFFFF_FFFF;
    v_op[3] = 2'b10; v_a[3] = 32'hFFFF_FFFF; v_b[3] = 32'hFFFF_FFFF; v_exp[3] = 32'hFFFF_FFFF;
    v_op[4] = 2'b10; v_a[4] = 32'h0000_0002; v_b[4] = 32'h8000_0000; v_exp[4] = 32'h0000_0001;
    issued = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 30 && (issued < 5 || exp_q.size() != 0); c++) begin
      in_valid = (issued < 5);
      if (issued < 5) begin
        op = v_op[issued]; rs1 = v_a[issued]; rs2 = v_b[issued]; in_tag = 5'(10 + issued);
      end
      cycle();
      if (acc) begin
        exp_q.push_back('{v_exp[issued], 5'(10 + issued)});
        issued++;
      end
      if (ret) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL signed_extra: unexpected result %h tag %0d", obs_res, obs_tag);
        end else begin
          e = exp_q.pop_front();
          if (obs_res !== e.res || obs_tag !== e.tag) begin
            n_fail++; $display("FAIL signed_result: got %h/tag %0d want %h/tag %0d", obs_res, obs_tag, e.res, e.tag);
          end
        end
      end
    end
    in_valid = 1'b0;
    n_checks++; if (exp_q.size() != 0 || issued != 5) begin n_fail++; $display("FAIL signed_timeout: pending %0d issued %0d want 0/5", exp_q.size(), issued); end
    exp_q.delete();
  endtask

  task automatic test_backpressure();
    exp_t e;
    int k;
    int n_acc;
    int n_ret;
    k = 1; n_acc = 0; n_ret = 0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    op = 2'(k); rs1 = $urandom; rs2 = $urandom; in_tag = 5'(k);
    for (int i = 0; i < 5; i++) begin
      cycle();
      if (acc) begin
        exp_q.push_back('{model(op, rs1, rs2), 5'(k)});
        n_acc++; k++;
        op = 2'(k); rs1 = $urandom; rs2 = $urandom; in_tag = 5'(k);
      end
      if (i >= 1) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_tag !== 5'd1 || exp_q.size() == 0 || result !== exp_q[0].res) begin
          n_fail++; $display("FAIL bp_hold%0d: valid %b tag %0d result %h want 1/1/%h", i, out_valid, out_tag, result,
                             (exp_q.size() != 0) ? exp_q[0].res : 32'd0);
        end
      end
    end
    n_checks++; if (n_acc != 2) begin n_fail++; $display("FAIL bp_accepts: got %0d want 2", n_acc); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
    out_ready = 1'b1;
    for (int c = 0; c < 20 && (k <= 3 || exp_q.size() != 0); c++) begin
      in_valid = (k <= 3);
      cycle();
      if (acc) begin
        exp_q.push_back('{model(op, rs1, rs2), 5'(k)});
        k++;
      end
      if (ret) begin
        n_ret++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL bp_extra: unexpected tag %0d", obs_tag);
        end else begin
          e = exp_q.pop_front();
          if (obs_res !== e.res || obs_tag !== e.tag) begin
            n_fail++; $display("FAIL bp_order: got %h/tag %0d want %h/tag %0d", obs_res, obs_tag, e.res, e.tag);
          end
        end
      end
    end
    in_valid = 1'b0;
    n_checks++; if (n_ret != 3 || exp_q.size() != 0) begin n_fail++; $display("FAIL bp_count: retired %0d pending %0d want 3/0", n_ret, exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_flush();
    exp_t e;
    int n_ret;
    n_ret = 0;
    out_ready = 1'b0;
    in_valid  = 1'b1; op = 2'b11; rs1 = 32'h1234_5678; rs2 = 32'h9ABC_DEF0;
    for (int i = 0; i < 2; i++) begin
      in_tag = 5'(4 + i);
      cycle();
      n_checks++; if (!acc) begin n_fail++; $display("FAIL flush_fill%0d: accept got 0 want 1", i); end
    end
    n_checks++; if (out_valid !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL flush_full: valid %b busy %b want 1/1", out_valid, busy); end
    flush = 1'b1; out_ready = 1'b1; in_tag = 5'd7;
    cycle();
    flush = 1'b0; in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid: got %b want 0", out_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy: got %b want 0", busy); end
    exp_q.delete();
    in_valid = 1'b1; op = 2'b01; rs1 = 32'hFFFF_FFF0; rs2 = 32'h0000_0100; in_tag = 5'd9;
    for (int c = 0; c < 10; c++) begin
      cycle();
      if (acc) begin
        exp_q.push_back('{model(op, rs1, rs2), 5'd9});
        in_valid = 1'b0;
      end
      if (ret) begin
        n_ret++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL flush_leak: unexpected result %h tag %0d", obs_res, obs_tag);
        end else begin
          e = exp_q.pop_front();
          if (obs_res !== e.res || obs_tag !== e.tag) begin
            n_fail++; $display("FAIL flush_next: got %h/tag %0d want %h/tag %0d", obs_res, obs_tag, e.res, e.tag);
          end
        end
      end
    end
    in_valid = 1'b0;
    n_checks++; if (n_ret != 1) begin n_fail++; $display("FAIL flush_retired: got %0d want 1", n_ret); end
    exp_q.delete();
  endtask

  task automatic test_reset_mid_op();
    exp_t e;
    int n_ret;
    n_ret = 0;
    out_ready = 1'b0;
    in_valid  = 1'b1; op = 2'b11; rs1 = 32'hFFFF_FFFF; rs2 = 32'hFFFF_FFFF; in_tag = 5'd3;
    cycle();
    cycle();
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1 || result === 32'd0) begin n_fail++; $display("FAIL rst_pre: valid %b result %h want 1/nonzero", out_valid, result); end
    #2;
    clrn = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_checks++; if (result !== 32'd0) begin n_fail++; $display("FAIL rst_result: got %h want 0", result); end
    exp_q.delete();
    @(negedge clk);
    clrn = 1'b1;
    @(posedge clk);
    #1;
`ifdef RV32M_MUL_PERF_CNT_EN
    n_checks++; if (mul_count !== 32'd0) begin n_fail++; $display("FAIL rst_mul_count: got %0d want 0", mul_count); end
`endif
    out_ready = 1'b1;
    for (int c = 0; c < 15; c++) begin
      in_valid = (c < 3);
      op = 2'(c); rs1 = $urandom; rs2 = $urandom; in_tag = 5'(20 + c);
      cycle();
      if (acc) exp_q.push_back('{model(op, rs1, rs2), 5'(20 + c)});
      if (ret) begin
        n_ret++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL rst_extra: unexpected tag %0d", obs_tag);
        end else begin
          e = exp_q.pop_front();
          if (obs_res !== e.res || obs_tag !== e.tag) begin
            n_fail++; $display("FAIL rst_after: got %h/tag %0d want %h/tag %0d", obs_res, obs_tag, e.res, e.tag);
          end
        end
      end
    end
    in_valid = 1'b0;
    n_checks++; if (n_ret != 3) begin n_fail++; $display("FAIL rst_retired: got %0d want 3", n_ret); end
`ifdef RV32M_MUL_PERF_CNT_EN
    n_checks++; if (mul_count !== 32'd3) begin n_fail++; $display("FAIL rst_count3: got %0d want 3", mul_count); end
`endif
    exp_q.delete();
  endtask

  task automatic test_random();
    exp_t e;
    int   n_ret;
    int   n_iss;
    n_ret = 0; n_iss = 0;
    op = 2'($urandom); rs1 = $urandom; rs2 = $urandom; in_tag = 5'($urandom);
    for (int c = 0; c < 400 && (n_iss < 60 || exp_q.size() != 0); c++) begin
      in_valid  = (n_iss < 60) && ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      // Sprinkle zero operands so the zero boundary is hit on signed ops.
      if (rs1[3:0] == 4'h0) rs2 = 32'd0;
      cycle();
      if (acc) begin
        exp_q.push_back('{model(op, rs1, rs2), in_tag});
        n_iss++;
        op = 2'($urandom); in_tag = 5'($urandom);
        rs1 = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
        rs2 = $urandom;
      end
      if (ret) begin
        n_ret++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL rand_extra: unexpected tag %0d", obs_tag);
        end else begin
          e = exp_q.pop_front();
          if (obs_res !== e.res || obs_tag !== e.tag) begin
            n_fail++; $display("FAIL rand_result: got %h/tag %0d want %h/tag %0d", obs_res, obs_tag, e.res, e.tag);
          end
        end
      end
    end
    in_valid = 1'b0;
    n_checks++; if (n_ret != 60 || exp_q.size() != 0) begin n_fail++; $display("FAIL rand_drain: retired %0d pending %0d want 60/0", n_ret, exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_signed();
    test_backpressure();
    test_flush();
    test_reset_mid_op();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
